// File: rtl/flash_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : flash_seq_ctrl_if
//  Purpose  : 68k-side bus strobes and flash-side handshake between a CPU
//             (master) and the flash sequencer (slave).
//  Signals  : AS_n, DS_n, RW_n, A[23:1], enable_maprom, FLASH_BUSY_n  -> slave
//             flash_access, flash_dtack_n, FLASH_OE_n, FLASH_WE_n,
//             FLASH_A19, flash_err                                   <- slave
//  Revision : 1.0  initial release
// ============================================================================
interface flash_seq_ctrl_if;
  logic        AS_n;
  logic        DS_n;
  logic        RW_n;
  logic [23:1] A;
  logic        enable_maprom;
  logic        FLASH_BUSY_n;
  logic        flash_access;
  logic        flash_dtack_n;
  logic        FLASH_OE_n;
  logic        FLASH_WE_n;
  logic        FLASH_A19;
  logic        flash_err;

  modport master (
    output AS_n, DS_n, RW_n, A, enable_maprom, FLASH_BUSY_n,
    input  flash_access, flash_dtack_n, FLASH_OE_n, FLASH_WE_n, FLASH_A19, flash_err
  );

  modport slave (
    input  AS_n, DS_n, RW_n, A, enable_maprom, FLASH_BUSY_n,
    output flash_access, flash_dtack_n, FLASH_OE_n, FLASH_WE_n, FLASH_A19, flash_err
  );
endinterface
`default_nettype wire

// File: rtl/flash_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flash_seq_ctrl
//  Purpose  : Decodes the flash window on a 68k bus (with optional MapROM
//             overlay) and sequences flash reads, writes and busy polling,
//             returning DTACK to the CPU.
//  Ports    : CLKCPU   - sole clock, rising edge
//             RESET_n  - asynchronous active-low reset
//             bus      - flash_seq_ctrl_if.slave (68k strobes, address,
//                        MapROM request, flash busy in; decode, DTACK,
//                        flash strobes, bank select, error flag out)
//  Revision : 1.0  initial release
// ============================================================================
module flash_seq_ctrl #(
  parameter logic [3:0] FLASH_BASE   = 4'hA,
  parameter int         RD_WAIT      = 2,
  parameter int         WE_WIDTH     = 2,
  parameter int         BUSY_TIMEOUT = 255
) (
  input  wire logic          CLKCPU,
  input  wire logic          RESET_n,
  flash_seq_ctrl_if.slave    bus
);

  // Terminal counter values: each phase ends on the clock where its counter
  // has reached the last index, so the phase lasts exactly N clocks.
  localparam logic [3:0] c_rd_last     = 4'(RD_WAIT - 1);
  localparam logic [3:0] c_we_last     = 4'(WE_WIDTH - 1);
  localparam logic [3:0] c_settle_last = 4'd1;
  localparam logic [7:0] c_poll_last   = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    WR_PULSE  = 3'd2,
    WR_SETTLE = 3'd3,
    BUSY_POLL = 3'd4,
    ACK       = 3'd5,
    TERM      = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] poll_q, poll_d;
  logic       oe_n_q, oe_n_d;
  logic       we_n_q, we_n_d;
  logic       dtack_n_q, dtack_n_d;
  logic       err_q, err_d;
  logic       ovl_q, ovl_d;
  logic       maprom_q, maprom_d;
  logic       cap_pend_q, cap_pend_d;
  logic       flash_hit;

  // Window decode: with MapROM off only the FLASH_BASE megabyte is flash;
  // with MapROM on the ROM ares at $F80000/$E00000 map to flash, plus the
  // low megabyte while the boot overlay is still active.
  always_comb begin
    flash_hit = 1'b0;
    if (!maprom_q) begin
      flash_hit = (bus.A[23:20] == FLASH_BASE);
    end else begin
      flash_hit = (ovl_q && (bus.A[23:20] == 4'h0)) ||
                  (bus.A[23:19] == 5'b11111) ||
                  (bus.A[23:19] == 5'b11100);
    end
  end

  assign bus.flash_access  = flash_hit;
  assign bus.FLASH_A19     = bus.A[19] | ovl_q;
  // DTACK drops with AS_n immediately so the CPU never sees a stale ack.
  assign bus.flash_dtack_n = dtack_n_q | bus.AS_n;
  assign bus.FLASH_OE_n    = oe_n_q;
  assign bus.FLASH_WE_n    = we_n_q;
  assign bus.flash_err     = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    dtack_n_d  = dtack_n_q;
    err_d      = err_q;
    ovl_d      = ovl_q;
    maprom_d   = maprom_q;
    cap_pend_d = cap_pend_q;

    // MapROM selection is latched once on the first edge out of reset.
    if (cap_pend_q) begin
      maprom_d   = bus.enable_maprom;
      cap_pend_d = 1'b0;
    end

    // Any write into $BFxxxx (CIA space) drops the boot overlay for good.
    if (!bus.AS_n && !bus.RW_n && (bus.A[23:16] == 8'hBF)) begin
      ovl_d = 1'b0;
    end

    if ((state_q != IDLE) && bus.AS_n) begin
      // CPU ended or aborted the cycle: release every strobe.
      state_d   = IDLE;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      dtack_n_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.AS_n && flash_hit) begin
            if (bus.RW_n) begin
              state_d = RD;
              oe_n_d  = 1'b0;
            end else if (!bus.DS_n) begin
              if (maprom_q) begin
                // Flash is write-protected while it shadows the ROM.
                state_d   = ACK;
                dtack_n_d = 1'b0;
              end else begin
                state_d = WR_PULSE;
                we_n_d  = 1'b0;
              end
            end
          end
        end
        RD: begin
          if (cnt_q == c_rd_last) begin
            state_d   = ACK;
            dtack_n_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        WR_PULSE: begin
          if (cnt_q == c_we_last) begin
            state_d = WR_SETTLE;
            we_n_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        WR_SETTLE: begin
          // Give the flash time to pull BUSY low before it is polled.
          if (cnt_q == c_settle_last) begin
            state_d = BUSY_POLL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        BUSY_POLL: begin
          if (bus.FLASH_BUSY_n) begin
            state_d   = ACK;
            dtack_n_d = 1'b0;
          end else if (poll_q == c_poll_last) begin
            state_d   = ACK;
            dtack_n_d = 1'b0;
            err_d     = 1'b1;
          end else begin
            poll_d = poll_q + 8'd1;
          end
        end
        ACK:     state_d = TERM;
        TERM:    state_d = TERM;
        default: state_d = IDLE;
      endcase
    end

    // Counters restart on every state change so each phase counts from 0.
    if (state_d != state_q) begin
      cnt_d  = 4'd0;
      poll_d = 8'd0;
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      poll_q     <= 8'd0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dtack_n_q  <= 1'b1;
      err_q      <= 1'b0;
      ovl_q      <= 1'b1;
      maprom_q   <= 1'b0;
      cap_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dtack_n_q  <= dtack_n_d;
      err_q      <= err_d;
      ovl_q      <= ovl_d;
      maprom_q   <= maprom_d;
      cap_pend_q <= cap_pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_seq_ctrl
//  Purpose  : Self-checking bench for flash_seq_ctrl: decode table, directed
//             bus cycles and randomized transactions against a cycle-count
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flash_seq_ctrl;

  localparam logic [3:0] FLASH_BASE   = 4'hA;
  localparam int         RD_WAIT      = 2;
  localparam int         WE_WIDTH     = 2;
  localparam int         BUSY_TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state tracked at transaction level.
  bit m_maprom;
  bit m_ovl;
  bit m_err;

  flash_seq_ctrl_if bus();

  flash_seq_ctrl #(
    .FLASH_BASE  (FLASH_BASE),
    .RD_WAIT     (RD_WAIT),
    .WE_WIDTH    (WE_WIDTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .CLKCPU (clk),
    .RESET_n(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.RW_n = 1'b1;
    bus.A = '0; bus.FLASH_BUSY_n = 1'b1;
  endtask

  // Window rules written straight from the address map.
  function automatic bit exp_access(input logic [23:0] a);
    logic [3:0] hi;
    logic [4:0] top5;
    hi   = a[23:20];
    top5 = a[23:19];
    if (!m_maprom) return hi == FLASH_BASE;
    return (m_ovl && hi == 4'h0) || top5 == 5'b11111 || top5 == 5'b11100;
  endfunction

  task automatic do_reset(input bit mr);
    @(negedge clk);
    rst_n = 1'b0;
    bus_idle();
    bus.enable_maprom = mr;
    #1;
    check("rst_oe",    int'(bus.FLASH_OE_n),    1);
    check("rst_we",    int'(bus.FLASH_WE_n),    1);
    check("rst_dtack", int'(bus.flash_dtack_n), 1);
    check("rst_err",   int'(bus.flash_err),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Request flips after capture; the latched choice must not follow it.
    bus.enable_maprom = ~mr;
    m_maprom = mr; m_ovl = 1'b1; m_err = 1'b0;
  endtask

  // Drive one bus cycle and watch it until DTACK or the edge limit.
  // Writes assert DS one clock after AS, as a 68k does. FLASH_BUSY_n is
  // held low from the start and released b clocks after WE returns high.
  task automatic run_txn(input logic [23:0] addr, input bit wr, input int b,
                         input int limit, output int dt, output int oe, output int we);
    int we_rise;
    bit seen_we;
    dt = 0; oe = 0; we = 0; we_rise = 0; seen_we = 0;
    @(negedge clk);
    bus.A = addr[23:1]; bus.RW_n = ~wr; bus.DS_n = wr; bus.AS_n = 1'b0;
    bus.FLASH_BUSY_n = ~wr;
    #1;
    check("access", int'(bus.flash_access), int'(exp_access(addr)));
    check("a19",    int'(bus.FLASH_A19),    int'(addr[19] | m_ovl));
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (bus.FLASH_OE_n == 1'b0) oe++;
      if (bus.FLASH_WE_n == 1'b0) begin
        we++; seen_we = 1'b1;
      end else if (seen_we && we_rise == 0) begin
        we_rise = k;
      end
      if (bus.flash_dtack_n == 1'b0) begin
        dt = k;
        break;
      end
      @(negedge clk);
      if (wr) bus.DS_n = 1'b0;
      if (we_rise != 0 && k >= we_rise + b) bus.FLASH_BUSY_n = 1'b1;
    end
  endtask

  task automatic release_bus(input string tag);
    @(negedge clk);
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.RW_n = 1'b1; bus.FLASH_BUSY_n = 1'b1;
    #1;
    check({tag, "_dtack_rel"}, int'(bus.flash_dtack_n), 1);
    @(posedge clk); #1;
    check({tag, "_oe_rel"}, int'(bus.FLASH_OE_n), 1);
    check({tag, "_we_rel"}, int'(bus.FLASH_WE_n), 1);
  endtask

  // Expected timing in clocks counted from the first edge with AS_n low:
  //  read : OE from edge 1, DTACK at edge RD_WAIT+1
  //  write: edge 1 waits for DS, WE low from edge 2 for WE_WIDTH clocks,
  //         two settle clocks, then polling until ready or the timeout.
  task automatic run_and_check(input string tag, input logic [23:0] addr,
                               input bit wr, input int b);
    bit acc;
    int e_dt, e_oe, e_we, dt, oe, we;
    int we_rise_edge, first_poll, ready, polls;
    acc = exp_access(addr);
    e_dt = 0; e_oe = 0; e_we = 0;
    if (acc && !wr) begin
      e_dt = RD_WAIT + 1; e_oe = RD_WAIT + 1;
    end else if (acc && m_maprom) begin
      e_dt = 2;
    end else if (acc) begin
      e_we         = WE_WIDTH;
      we_rise_edge = 2 + WE_WIDTH;
      first_poll   = we_rise_edge + 2 + 1;
      ready        = we_rise_edge + b + 1;
      polls        = (ready < first_poll) ? 1 : ready - first_poll + 1;
      if (polls > BUSY_TIMEOUT) begin
        polls = BUSY_TIMEOUT;
        m_err = 1'b1;
      end
      e_dt = first_poll + polls - 1;
    end
    run_txn(addr, wr, b, acc ? 300 : 8, dt, oe, we);
    check({tag, "_dtack_edge"}, dt, e_dt);
    check({tag, "_oe_clocks"},  oe, e_oe);
    check({tag, "_we_clocks"},  we, e_we);
    check({tag, "_err"}, int'(bus.flash_err), int'(m_err));
    release_bus(tag);
    if (wr && addr[23:16] == 8'hBF) m_ovl = 1'b0;
  endtask

  typedef struct {
    bit          mr;
    bit          clr;
    logic [23:0] addr;
    bit          acc;
    bit          a19;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [23:0] ra;
    bus_idle();
    bus.enable_maprom = 1'b0;

    vecs[0]  = '{0, 0, 24'hA00000, 1, 1};
    vecs[1]  = '{0, 0, 24'h000000, 0, 1};
    vecs[2]  = '{0, 0, 24'hF80000, 0, 1};
    vecs[3]  = '{1, 0, 24'h000000, 1, 1};
    vecs[4]  = '{1, 0, 24'hF80000, 1, 1};
    vecs[5]  = '{1, 0, 24'hE00000, 1, 1};
    vecs[6]  = '{1, 0, 24'hE80000, 0, 1};
    vecs[7]  = '{1, 0, 24'hA00000, 0, 1};
    vecs[8]  = '{1, 1, 24'h000000, 0, 0};
    vecs[9]  = '{1, 1, 24'hF00000, 0, 0};
    vecs[10] = '{0, 1, 24'hA80000, 1, 1};
    vecs[11] = '{1, 1, 24'hFFFFFE, 1, 1};
    vecs[12] = '{0, 1, 24'h100000, 0, 0};

    do_reset(1'b0);

    // Decode table
    for (int i = 0; i < 13; i++) begin
      do_reset(vecs[i].mr);
      if (vecs[i].clr) begin
        @(negedge clk);
        bus.A = 23'(24'hBF0000 >> 1); bus.RW_n = 1'b0; bus.AS_n = 1'b0;
        @(negedge clk);
        bus.AS_n = 1'b1; bus.RW_n = 1'b1;
      end
      @(negedge clk);
      bus.A = vecs[i].addr[23:1];
      #1;
      check($sformatf("tbl%0d_access", i), int'(bus.flash_access), int'(vecs[i].acc));
      check($sformatf("tbl%0d_a19", i),    int'(bus.FLASH_A19),    int'(vecs[i].a19));
    end

    // Read at $A00000, edge by edge
    do_reset(1'b0);
    @(negedge clk);
    bus.A = 23'(24'hA00000 >> 1); bus.RW_n = 1'b1; bus.DS_n = 1'b0; bus.AS_n = 1'b0;
    for (int e = 1; e <= RD_WAIT + 1; e++) begin
      @(posedge clk); #1;
      check($sformatf("rd_oe_e%0d", e), int'(bus.FLASH_OE_n), 0);
      check($sformatf("rd_dtack_e%0d", e), int'(bus.flash_dtack_n),
            (e == RD_WAIT + 1) ? 0 : 1);
    end
    release_bus("rd_seq");

    // MapROM overlay and its clearing by a CIA write
    do_reset(1'b1);
    run_and_check("mr_rd0", 24'h000000, 1'b0, 0);
    run_and_check("ovl_clr", 24'hBFE001, 1'b1, 0);
    @(negedge clk);
    bus.A = '0;
    #1;
    check("ovl_cleared_access", int'(bus.flash_access), 0);

    // Program cycle with 10 busy clocks
    do_reset(1'b0);
    run_and_check("wr_busy10", 24'hA10000, 1'b1, 10);

    // Write-protected write under MapROM
    do_reset(1'b1);
    run_and_check("wp_wr", 24'hF80000, 1'b1, 0);

    // AS_n abort one clock into a read
    do_reset(1'b0);
    @(negedge clk);
    bus.A = 23'(24'hA00000 >> 1); bus.RW_n = 1'b1; bus.DS_n = 1'b0; bus.AS_n = 1'b0;
    @(posedge clk); #1;
    check("abort_oe_low", int'(bus.FLASH_OE_n), 0);
    @(negedge clk);
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    @(posedge clk); #1;
    check("abort_oe_high", int'(bus.FLASH_OE_n), 1);
    @(posedge clk); #1;
    check("abort_no_dtack", int'(bus.flash_dtack_n), 1);
    run_and_check("post_abort_rd", 24'hA00000, 1'b0, 0);

    // Busy stuck low: timeout, sticky error
    do_reset(1'b0);
    run_and_check("wr_timeout", 24'hA10000, 1'b1, 1000);
    run_and_check("rd_after_to", 24'hA00000, 1'b0, 0);

    // Reset in the middle of the WE pulse (error flag is still set here)
    @(negedge clk);
    bus.A = 23'(24'hA10000 >> 1); bus.RW_n = 1'b0; bus.DS_n = 1'b0; bus.AS_n = 1'b0;
    bus.FLASH_BUSY_n = 1'b0;
    @(posedge clk); #1;
    check("midwr_we_low", int'(bus.FLASH_WE_n), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midwr_we_async",    int'(bus.FLASH_WE_n),    1);
    check("midwr_oe_async",    int'(bus.FLASH_OE_n),    1);
    check("midwr_dtack_async", int'(bus.flash_dtack_n), 1);
    check("midwr_err_async",   int'(bus.flash_err),     0);

    // Randomized transactions
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) do_reset(1'($urandom_range(0, 1)));
      ra = 24'($urandom);
      case ($urandom_range(0, 5))
        0: ra[23:20] = FLASH_BASE;
        1: ra[23:20] = 4'h0;
        2: ra[23:19] = 5'b11111;
        3: ra[23:19] = 5'b11100;
        4: ra[23:16] = 8'hBF;
        default: ;
      endcase
      run_and_check($sformatf("rnd%0d", i), ra, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
